// File: rtl/stopwatch_ctrl.sv
// Control sequencer for the BCD stopwatch: debounces the two buttons, runs the
// RUN/PAUSE/LAP/IDLE state machine and paces the counter with a prescaled tick.
module stopwatch_ctrl #(
    parameter int TICK_DIV   = 100,
    parameter int DEB_CYCLES = 16
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        btn_ss,
    input  logic        btn_lap,
    input  logic [39:0] time_in,
    output logic        sw_start,
    output logic        sw_clr,
    output logic [39:0] disp_time,
    output logic [39:0] lap_time,
    output logic [3:0]  lap_cnt,
    output logic [1:0]  state,
    output logic        ovf
);

    localparam int DCW = $clog2(DEB_CYCLES + 1);
    localparam int PCW = $clog2(TICK_DIV);
    localparam logic [39:0] FULL_SCALE = 40'h99_59_599999;
    localparam logic [DCW-1:0] DEB_LAST = DCW'(DEB_CYCLES - 1);
    localparam logic [PCW-1:0] PRESC_LAST = PCW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_n;
    logic [1:0]       sync1;
    logic [1:0]       sync2;
    logic [1:0]       deb;
    logic [1:0]       evt;
    logic [DCW-1:0]   deb_cnt [2];
    logic [PCW-1:0]   presc;
    logic             clr_pulse;
    logic             ss_evt;
    logic             lap_evt;
    logic             running;
    logic             tick;
    logic             capture;
    logic             set_ovf;
    logic             go_idle;
    logic             presc_run;

    // Index 0 is start/stop, index 1 is lap/reset. The event fires only on a
    // debounced press; a debounced release just re-arms the button.
    always_ff @(posedge clk) begin
        if (clr) begin
            sync1      <= '0;
            sync2      <= '0;
            deb        <= '0;
            evt        <= '0;
            deb_cnt[0] <= '0;
            deb_cnt[1] <= '0;
        end else begin
            sync1 <= {btn_lap, btn_ss};
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                evt[i] <= 1'b0;
                if (sync2[i] != deb[i]) begin
                    if (deb_cnt[i] == DEB_LAST) begin
                        deb[i]     <= sync2[i];
                        deb_cnt[i] <= '0;
                        evt[i]     <= sync2[i];
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 1'b1;
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    assign ss_evt  = evt[0];
    assign lap_evt = evt[1] & ~evt[0];
    assign running = (state_q == RUN) || (state_q == LAP);

    // The prescaler does not advance on the edge into PAUSE, so a resume picks
    // up exactly where the paused period left off and a deferred tick is kept.
    always_comb begin
        state_n   = state_q;
        tick      = 1'b0;
        capture   = 1'b0;
        set_ovf   = 1'b0;
        go_idle   = 1'b0;
        presc_run = 1'b0;
        case (state_q)
            IDLE: begin
                if (ss_evt) state_n = RUN;
            end
            RUN: begin
                if (ss_evt) begin
                    state_n = PAUSE;
                end else if (lap_evt) begin
                    state_n = LAP;
                    capture = 1'b1;
                end
            end
            LAP: begin
                if (ss_evt) state_n = PAUSE;
                else if (lap_evt) state_n = RUN;
            end
            PAUSE: begin
                if (ss_evt) begin
                    if (!ovf) state_n = RUN;
                end else if (lap_evt) begin
                    state_n = IDLE;
                    go_idle = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        if (running && state_n != PAUSE) begin
            presc_run = 1'b1;
            if (presc == PRESC_LAST) begin
                if (time_in == FULL_SCALE) begin
                    state_n   = PAUSE;
                    set_ovf   = 1'b1;
                    capture   = 1'b0;
                    presc_run = 1'b0;
                end else begin
                    tick = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= IDLE;
            presc     <= '0;
            sw_start  <= 1'b0;
            clr_pulse <= 1'b0;
            lap_time  <= '0;
            lap_cnt   <= '0;
            ovf       <= 1'b0;
        end else begin
            state_q   <= state_n;
            sw_start  <= tick;
            clr_pulse <= go_idle;
            if (state_q == IDLE) begin
                presc <= '0;
            end else if (presc_run) begin
                presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
            end
            if (go_idle) begin
                lap_time <= '0;
                lap_cnt  <= '0;
                ovf      <= 1'b0;
            end else begin
                if (capture) begin
                    lap_time <= time_in;
                    lap_cnt  <= (lap_cnt == 4'd15) ? 4'd15 : lap_cnt + 1'b1;
                end
                if (set_ovf) ovf <= 1'b1;
            end
        end
    end

    assign sw_clr    = clr | clr_pulse;
    assign disp_time = (state_q == LAP) ? lap_time : time_in;
    assign state     = state_q;

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control sequencer for the BCD stopwatch counter. Debounces two push-buttons (start/stop, lap/reset) and drives the counter's level-sensitive start enable with a prescaled one-cycle tick. Drives the counter's clear, captures lap times, freezes the display, and stops the counter at full scale. It sits between board buttons and the stopwatch counter, and feeds the display path.

Parameters:
TICK_DIV, 100, clk cycles per counter increment while running (>=2)
DEB_CYCLES, 16, consecutive stable synced cycles required to accept a button level change (>=1)

Ports:
clk  in  1  system clock, all logic on posedge
clr  in  1  synchronous active-high reset
btn_ss  in  1  raw start/stop button, async, active-high
btn_lap  in  1  raw lap/reset button, async, active-high
time_in  in  40  live counter value {hr[7:0], min[7:0], sec[23:0]}, BCD
sw_start  out  1  counter enable, one-cycle pulse per tick
sw_clr  out  1  counter clear
disp_time  out  40  value to display: time_in live, or lap_time when frozen
lap_time  out  40  last captured lap value
lap_cnt  out  4  laps taken since last reset, saturates at 15
state  out  2  0=IDLE 1=RUN 2=PAUSE 3=LAP
ovf  out  1  full-scale stop flag

Behaviour:
- Reset (clr=1): state=IDLE, lap_time=0, lap_cnt=0, ovf=0, prescaler=0, sw_start=0, debounced levels=0. sw_clr=1 combinationally while clr=1.
- Button path, per button:
  - 2-flop synchronizer.
  - Debounced level flips only after the synced value differs from it for DEB_CYCLES consecutive cycles; any agreeing cycle resets the count.
  - Event = one-cycle pulse on debounced 0->1. Release produces no event.
  - Raw edge is first sampled at cycle 0; event is high in cycle DEB_CYCLES+2. The state register updates on that cycle's edge.
- Simultaneous ss_evt and lap_evt: ss_evt wins, lap_evt dropped.
- FSM transitions:
  - IDLE: ss_evt -> RUN, prescaler=0. lap_evt ignored.
  - RUN: ss_evt -> PAUSE. lap_evt -> LAP; capture lap_time<=time_in; lap_cnt++ (saturating).
  - LAP: lap_evt -> RUN (display released, no capture). ss_evt -> PAUSE.
  - PAUSE: ss_evt -> RUN, only if ovf=0; ignored otherwise. lap_evt -> IDLE.
- Entering IDLE from PAUSE:
  - sw_clr high exactly one cycle, the first IDLE cycle.
  - lap_time=0, lap_cnt=0, ovf=0.
- sw_clr is otherwise 0.
- Prescaler, active in RUN and LAP only:
  - Counts 0..TICK_DIV-1 and wraps.
  - sw_start=1 (registered) for exactly the cycle after the count equals TICK_DIV-1.
  - Value is held in PAUSE, so resume continues the partial period. Cleared in IDLE.
  - No sw_start in IDLE or PAUSE. A tick scheduled in the same cycle as the transition to PAUSE is suppressed.
- Full scale = time_in == 40'h99_59_599999.
  - If full scale holds when a tick would issue: sw_start stays 0, state -> PAUSE, ovf=1.
  - ovf holds until IDLE or clr.
- disp_time = lap_time in LAP. Otherwise disp_time = time_in (combinational mux).
- clr mid-operation overrides everything within one cycle; any pending event is discarded.
- Button held: a single event only; re-press requires debounced release first.

Test Plan:
(Bench: TICK_DIV=4, DEB_CYCLES=3.)
1. Reset, then hold btn_ss 10 cycles -> ss_evt in cycle 5; state=RUN next cycle; sw_start pulses every 4 cycles. sw_clr=1 only while clr=1.
2. Bounce btn_ss 1-0-1-0 at 1-cycle intervals, then release -> no event, state stays IDLE. Glitch of 2 cycles -> no event.
3. RUN with time_in=40'h00_01_123456, press lap -> lap_time=40'h00_01_123456, lap_cnt=1, state=LAP. Vary time_in -> disp_time stays frozen, sw_start keeps pulsing. Press lap -> RUN, disp_time tracks time_in.
4. RUN, press ss at prescaler=2 -> PAUSE, no sw_start. Resume -> first sw_start after 2 further counts. Press ss and lap in the same cycle while in RUN -> PAUSE, lap_cnt unchanged.
5. From PAUSE, press lap -> IDLE; sw_clr exactly one cycle; lap_cnt=0, lap_time=0. 16 laps beforehand -> lap_cnt reads 15, not 0.
6. RUN with time_in=40'h99_59_599999 at tick -> sw_start stays 0, state=PAUSE, ovf=1. ss press ignored. Lap press -> IDLE, ovf=0. clr asserted during RUN -> state=IDLE next cycle, all outputs at reset values.
